// File: rtl/ecpeta_pkg.sv
// Shared constants and parameter legality check for the ecpeta approximate adder.
// Build option: ECPETA_COMP_EN enables the predicted carry into the exact upper part.
package ecpeta_pkg;
  localparam int ECPETA_N = 16;
  localparam int ECPETA_K = 8;

  function automatic bit ecpeta_params_ok(input int n, input int k);
    return (n >= 3) && (k >= 2) && (k <= n - 1);
  endfunction
endpackage

// File: rtl/ecpeta_lower.sv
// Carry-free saturating lower part of the ecpeta adder; also emits the predicted carry.
// Build option: ECPETA_COMP_EN keeps bit K-1 exact and predicts c from g[K-1].
module ecpeta_lower
  import ecpeta_pkg::*;
#(
  parameter int K = ECPETA_K
) (
  input  logic [K-1:0] a_i,
  input  logic [K-1:0] b_i,
  output logic [K-1:0] lo_o,
  output logic         c_o
);
`ifdef ECPETA_COMP_EN
  localparam int TOP = K - 2;
`else
  localparam int TOP = K - 1;
`endif

  logic [K-1:0] g, p;
  logic         sat;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Once a generate is seen scanning downward, it and every lower bit saturate to 1.
  always_comb begin
    lo_o = p;
    sat  = 1'b0;
    for (int i = TOP; i >= 0; i--) begin
      sat     = sat | g[i];
      lo_o[i] = sat | p[i];
    end
`ifdef ECPETA_COMP_EN
    c_o = g[K-1];
`else
    c_o = 1'b0;
`endif
  end
endmodule

// File: rtl/ecpeta.sv
// Registered error-tolerant approximate adder: exact upper N-K bits, saturating lower K bits.
// Build option: ECPETA_COMP_EN links the parts with a single predicted carry.
module ecpeta
  import ecpeta_pkg::*;
#(
  parameter int N = ECPETA_N,
  parameter int K = ECPETA_K
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  output logic [N-1:0] sum
);
  if (!ecpeta_params_ok(N, K)) begin : g_bad_params
    $error("ecpeta: illegal N/K combination");
  end

  logic [K-1:0]   lo;
  logic           c;
  logic [N-K-1:0] hi;
  logic [N-1:0]   sum_d, sum_q;
  logic           vld_q;

  ecpeta_lower #(.K(K)) u_lower (
    .a_i  (A[K-1:0]),
    .b_i  (B[K-1:0]),
    .lo_o (lo),
    .c_o  (c)
  );

  // Upper carry-out is dropped, so the sum wraps modulo 2^N.
  assign hi    = A[N-1:K] + B[N-1:K] + (N-K)'(c);
  assign sum_d = {hi, lo};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) sum_q <= sum_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = vld_q;
endmodule

// File: tb/tb_ecpeta.sv
// Directed and randomized checks of the ecpeta approximate adder (N=16, K=8).
module tb_ecpeta;
  import ecpeta_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A, B;
  logic        out_valid;
  logic [15:0] sum;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ecpeta #(.N(16), .K(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .sum       (sum)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Reference: locate the highest generate in the scan window, saturate from there down.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] g, p;
    logic [7:0]  lo, hi;
    logic        c, found;
    int          top, pos;
    g = a & b;
    p = a ^ b;
`ifdef ECPETA_COMP_EN
    c = g[7];  top = 6;
`else
    c = 1'b0;  top = 7;
`endif
    found = 1'b0;
    pos   = 0;
    for (int j = top; j >= 0; j--)
      if (!found && g[j]) begin found = 1'b1; pos = j; end
    lo = p[7:0];
    if (found) lo = lo | (8'hFF >> (7 - pos));
    hi = a[15:8] + b[15:8] + {7'd0, c};
    return {hi, lo};
  endfunction

  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp);
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    chk({tag, ".sum"}, sum, exp);
    chk({tag, ".vld"}, {15'd0, out_valid}, 16'd1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
    @(posedge clk); #1;
    chk("rst.sum", sum, 16'h0000);
    chk("rst.vld", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst.sum", sum, 16'h0000);
    chk("post_rst.vld", {15'd0, out_valid}, 16'd0);

    apply("sat",  16'h1234, 16'h4321, 16'h553F);
    apply("nogen", 16'h0F0F, 16'h00F0, 16'h0FFF);
`ifdef ECPETA_COMP_EN
    apply("cpred", 16'h0080, 16'h0080, 16'h0100);
    apply("wrap0", 16'hFF80, 16'h0080, 16'h0000);
`else
    apply("cpred", 16'h0080, 16'h0080, 16'h00FF);
    apply("wrap0", 16'hFF80, 16'h0080, 16'hFFFF);
`endif
    apply("maxerr", 16'hFFFF, 16'h0001, 16'hFFFF);

    apply("strm0", 16'h0001, 16'h0002, 16'h0003);
    apply("strm1", 16'h0100, 16'h0100, 16'h0200);
    @(negedge clk);
    in_valid = 1'b0; A = 16'h5555; B = 16'hAAAA;
    @(posedge clk); #1;
    chk("hold.sum", sum, 16'h0200);
    chk("hold.vld", {15'd0, out_valid}, 16'd0);

    for (int n = 0; n < 3000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      apply("rand", ra, rb, model(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
